sram_arbiter: RTL

//  Shares one 32-bit asynchronous SRAM bank (base_ram or ext_ram: 20-bit word address,
//  4 byte enables, ce_n/oe_n/we_n) between two requesters, port 0 (instruction fetch)
//  and port 1 (data). Sequences each access with setup, pulse and hold timing.

---
 rtl/sram_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 32-bit asynchronous SRAM bank between an instruction-fetch
// port (m0) and a data port (m1). Every SRAM pin is driven straight from a register.
module sram_arbiter #(
   parameter int unsigned READ_WAIT  = 1,
   parameter int unsigned WRITE_WAIT = 0,
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [19:0] m0_addr,
   input  logic [3:0]  m0_be,
   input  logic [31:0] m0_wdata,
   output logic [31:0] m0_rdata,
   output logic        m0_ack,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [19:0] m1_addr,
   input  logic [3:0]  m1_be,
   input  logic [31:0] m1_wdata,
   output logic [31:0] m1_rdata,
   output logic        m1_ack,
   output logic [19:0] sram_addr,
   output logic [31:0] sram_dq_o,
   input  logic [31:0] sram_dq_i,
   output logic        sram_dq_oe,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_we_n,
   output logic [3:0]  sram_be_n
);

   localparam int unsigned BW = 4;
   localparam int unsigned CW = 4;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_READ   = 3'd1,
      S_WSETUP = 3'd2,
      S_WPULSE = 3'd3,
      S_WHOLD  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          any_req, sel, sel_we;
   logic          grant_q, last_grant_q;
   logic [BW-1:0] be_q, cur_be;
   logic          ce_n_d, oe_n_d, we_n_d, dq_oe_d, m0_ack_d, m1_ack_d;
   logic [BW-1:0] be_n_d;

   // Arbitration: single requester wins; on contention fixed priority or alternate.
   always_comb begin
      any_req = m0_req | m1_req;
      sel     = m1_req;
      if (m0_req && m1_req) begin
         sel = (FIXED_PRIO != 0) ? 1'b1 : ~last_grant_q;
      end
      sel_we = sel ? m1_we : m0_we;
      cur_be = (state_q == S_IDLE) ? (sel ? m1_be : m0_be) : be_q;
   end

   // Next state and wait counter; the counter is loaded on entry and counts to zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               if (sel_we) begin
                  state_d = S_WSETUP;
                  cnt_d   = '0;
               end else begin
                  state_d = S_READ;
                  cnt_d   = CW'(READ_WAIT);
               end
            end
         end
         S_READ: begin
            if (cnt_q == '0) state_d = S_DONE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         S_WSETUP: begin
            state_d = S_WPULSE;
            cnt_d   = CW'(WRITE_WAIT);
         end
         S_WPULSE: begin
            if (cnt_q == '0) state_d = S_WHOLD;
            else             cnt_d   = cnt_q - CW'(1);
         end
         S_WHOLD: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode from the upcoming state so the pins register in step with it.
   always_comb begin
      ce_n_d   = 1'b1;
      oe_n_d   = 1'b1;
      we_n_d   = 1'b1;
      be_n_d   = '1;
      dq_oe_d  = 1'b0;
      m0_ack_d = 1'b0;
      m1_ack_d = 1'b0;
      case (state_d)
         S_READ: begin
            ce_n_d = 1'b0;
            oe_n_d = 1'b0;
            be_n_d = ~cur_be;
         end
         S_WSETUP, S_WHOLD: begin
            ce_n_d  = 1'b0;
            dq_oe_d = 1'b1;
            be_n_d  = ~cur_be;
         end
         S_WPULSE: begin
            ce_n_d  = 1'b0;
            we_n_d  = 1'b0;
            dq_oe_d = 1'b1;
            be_n_d  = ~cur_be;
         end
         S_DONE: begin
            m0_ack_d = ~grant_q;
            m1_ack_d = grant_q;
         end
         default: ;
      endcase
   end

   // State register and registered SRAM controls / acks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         sram_ce_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
         sram_we_n  <= 1'b1;
         sram_be_n  <= '1;
         sram_dq_oe <= 1'b0;
         m0_ack     <= 1'b0;
         m1_ack     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sram_ce_n  <= ce_n_d;
         sram_oe_n  <= oe_n_d;
         sram_we_n  <= we_n_d;
         sram_be_n  <= be_n_d;
         sram_dq_oe <= dq_oe_d;
         m0_ack     <= m0_ack_d;
         m1_ack     <= m1_ack_d;
      end
   end

   // Transaction latch at grant time, and read data capture on the last READ edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         be_q         <= '0;
         sram_addr    <= '0;
         sram_dq_o    <= '0;
         m0_rdata     <= '0;
         m1_rdata     <= '0;
      end else begin
         if (state_q == S_IDLE && any_req) begin
            grant_q      <= sel;
            last_grant_q <= sel;
            be_q         <= sel ? m1_be : m0_be;
            sram_addr    <= sel ? m1_addr : m0_addr;
            sram_dq_o    <= sel ? m1_wdata : m0_wdata;
         end
         if (state_q == S_READ && cnt_q == '0) begin
            if (grant_q) m1_rdata <= sram_dq_i;
            else         m0_rdata <= sram_dq_i;
         end
      end
   end

endmodule
